// File: rtl/pulse_req_scheduler_if.sv
// Request/engine handshake bundle between requesters, the shared engine and the scheduler.
interface pulse_req_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0] req_pls;
    logic             eng_done;
    logic             ovr_clr;
    logic             eng_start;
    logic [ID_W-1:0]  eng_sel;
    logic [N_REQ-1:0] ack_pls;
    logic [N_REQ-1:0] overrun;
    logic             timeout;
    logic             busy;

    modport slave (
        input  req_pls, eng_done, ovr_clr,
        output eng_start, eng_sel, ack_pls, overrun, timeout, busy
    );

    modport master (
        output req_pls, eng_done, ovr_clr,
        input  eng_start, eng_sel, ack_pls, overrun, timeout, busy
    );
endinterface

// File: rtl/pulse_req_scheduler.sv
// Round-robin scheduler sharing one slow-domain engine between N_REQ pulse requesters,
// with per-channel pending/overrun lanes and an engine-response timeout.

module pulse_req_lane (
    input  logic s_clk,
    input  logic srst_n,
    input  logic i_req,
    input  logic i_clr,
    input  logic i_ovr_clr,
    output logic o_pending,
    output logic o_overrun
);
    logic r_pending;
    logic r_overrun;

    // A fresh request beats the completion clear, so a re-request in the ACK/ERR cycle is kept.
    always_ff @(posedge s_clk or negedge srst_n) begin
        if (!srst_n) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_pending <= i_req | (r_pending & ~i_clr);
            r_overrun <= (r_overrun & ~i_ovr_clr) | (i_req & r_pending & ~i_clr);
        end
    end

    assign o_pending = r_pending;
    assign o_overrun = r_overrun;
endmodule

module pulse_req_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TMO_CYC = 16
) (
    input  logic                  s_clk,
    input  logic                  srst_n,
    pulse_req_scheduler_if.slave  bus
);
    localparam int CNT_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_sel;
    logic [ID_W-1:0]  r_last;
    logic [CNT_W-1:0] r_cnt;

    logic [N_REQ-1:0] w_pending;
    logic [N_REQ-1:0] w_overrun;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_sel_oh;
    logic [ID_W-1:0]  w_pick;
    logic             w_any;
    logic             w_expired;
    int               w_idx;

    logic w_start;
    logic w_ack;
    logic w_tmo;
    logic w_busy;
    logic w_done_clr;

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        pulse_req_lane u_lane (
            .s_clk     (s_clk),
            .srst_n    (srst_n),
            .i_req     (bus.req_pls[g]),
            .i_clr     (w_clr[g]),
            .i_ovr_clr (bus.ovr_clr),
            .o_pending (w_pending[g]),
            .o_overrun (w_overrun[g])
        );
    end

    // Scan from furthest to nearest offset so the nearest pending channel after last_id wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = (int'(r_last) + k) % N_REQ;
            if (w_pending[w_idx]) begin
                w_any  = 1'b1;
                w_pick = ID_W'(w_idx);
            end
        end
    end

    assign w_sel_oh  = N_REQ'(1) << r_sel;
    assign w_expired = (r_cnt == CNT_W'(TMO_CYC - 1));
    assign w_clr     = w_done_clr ? w_sel_oh : '0;

    always_ff @(posedge s_clk or negedge srst_n) begin
        if (!srst_n) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.eng_done)   w_state_nxt = S_ACK;
                else if (w_expired) w_state_nxt = S_ERR;
            end
            S_ACK:   w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start    = 1'b0;
        w_ack      = 1'b0;
        w_tmo      = 1'b0;
        w_busy     = 1'b1;
        w_done_clr = 1'b0;
        case (r_state)
            S_IDLE:  w_busy = 1'b0;
            S_ISSUE: w_start = 1'b1;
            S_ACK: begin
                w_ack      = 1'b1;
                w_done_clr = 1'b1;
            end
            S_ERR: begin
                w_tmo      = 1'b1;
                w_done_clr = 1'b1;
            end
            default: ;
        endcase
    end

    // last_id restarts at N_REQ-1 so channel 0 is searched first after reset.
    always_ff @(posedge s_clk or negedge srst_n) begin
        if (!srst_n) begin
            r_sel  <= '0;
            r_last <= ID_W'(N_REQ - 1);
            r_cnt  <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_sel  <= w_pick;
                r_last <= w_pick;
            end
            if (r_state == S_ISSUE)     r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.eng_start = w_start;
    assign bus.eng_sel   = r_sel;
    assign bus.ack_pls   = w_ack ? w_sel_oh : '0;
    assign bus.overrun   = w_overrun;
    assign bus.timeout   = w_tmo;
    assign bus.busy      = w_busy;

    a_ack_onehot: assert property (@(posedge s_clk) disable iff (!srst_n)
        $onehot0(bus.ack_pls));
    a_sel_stable: assert property (@(posedge s_clk) disable iff (!srst_n)
        (r_state != S_IDLE) |=> (r_state == S_IDLE || $stable(r_sel)));
endmodule

// File: tb/tb_pulse_req_scheduler.sv
// Scoreboard bench: a time-based reference model predicts start/ack/timeout events per cycle.
module tb_pulse_req_scheduler;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int TMO = 16;

    typedef struct {
        int cyc;
        int kind;   // 0 start, 1 ack, 2 timeout
        int ch;
    } ev_t;

    logic s_clk  = 1'b0;
    logic srst_n = 1'b0;

    pulse_req_scheduler_if #(.N_REQ(N), .ID_W(IW)) bus ();

    pulse_req_scheduler #(.N_REQ(N), .ID_W(IW), .TMO_CYC(TMO)) dut (
        .s_clk  (s_clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    initial forever #5 s_clk = ~s_clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    ev_t sbq[$];
    int  g_log[$];
    int  g_cyc[$];
    int  a_log[$];
    int  a_cyc[$];
    int  t_cyc[$];

    int  eng_lat = 1;
    bit  rnd_lat = 0;
    bit  stray   = 0;
    int  cd      = 0;

    // reference model state
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovr;
    int m_last, m_cur, m_start, m_end;
    bit exp_busy;
    int exp_sel;

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference model: processes the finished cycle at each rising edge and schedules events.
    initial forever begin
        @(posedge s_clk);
        if (!srst_n) begin
            m_pend = '0; m_ovr = '0; m_last = N - 1; m_cur = -1;
            m_start = -1; m_end = -1; exp_busy = 0; exp_sel = 0;
            sbq.delete();
        end else begin
            logic [N-1:0] r, clr, oset;
            r   = bus.req_pls;
            clr = '0;
            if (m_cur >= 0 && cyc == m_end) begin
                clr[m_cur] = 1'b1;
            end else if (m_cur >= 0 && m_end < 0 && cyc > m_start) begin
                if (bus.eng_done) begin
                    m_end = cyc + 1;
                    sbq.push_back('{cyc + 1, 1, m_cur});
                end else if (cyc == m_start + TMO) begin
                    m_end = cyc + 1;
                    sbq.push_back('{cyc + 1, 2, m_cur});
                end
            end else if (m_cur < 0) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_last + k) % N;
                    if (m_cur < 0 && m_pend[idx]) begin
                        m_cur = idx; m_start = cyc + 1; m_end = -1; m_last = idx;
                        sbq.push_back('{cyc + 1, 0, idx});
                    end
                end
            end
            oset   = r & m_pend & ~clr;
            m_pend = (m_pend & ~clr) | r;
            m_ovr  = (bus.ovr_clr ? '0 : m_ovr) | oset;
            if (m_cur >= 0 && cyc == m_end) m_cur = -1;
            exp_busy = (m_cur >= 0) && (cyc + 1 >= m_start);
            exp_sel  = (m_cur >= 0) ? m_cur : exp_sel;
        end
        cyc++;
    end

    // Monitor: pops due events whenever the DUT presents an output or one is due.
    initial forever begin
        @(negedge s_clk);
        if (!srst_n) begin
            chk("rst_outputs",
                int'({bus.eng_start, bus.eng_sel, bus.ack_pls, bus.overrun, bus.timeout, bus.busy}), 0);
        end else begin
            bit due, e_start, e_to;
            int e_ch;
            logic [N-1:0] e_ack;
            ev_t e;
            due = 0; e_start = 0; e_to = 0; e_ack = '0; e_ch = 0;
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                if (e.cyc < cyc) chk("missed_event_kind", -1, e.kind);
                else begin
                    due = 1; e_ch = e.ch;
                    if (e.kind == 0) e_start = 1;
                    if (e.kind == 1) e_ack[e.ch] = 1'b1;
                    if (e.kind == 2) e_to = 1;
                end
            end
            if (due || bus.eng_start || bus.ack_pls != '0 || bus.timeout) begin
                chk("eng_start", int'(bus.eng_start), int'(e_start));
                chk("ack_pls", int'(bus.ack_pls), int'(e_ack));
                chk("timeout", int'(bus.timeout), int'(e_to));
                if (e_start) chk("start_sel", int'(bus.eng_sel), e_ch);
            end
            chk("busy", int'(bus.busy), int'(exp_busy));
            chk("overrun", int'(bus.overrun), int'(m_ovr));
            if (exp_busy) chk("eng_sel", int'(bus.eng_sel), exp_sel);
            if (bus.eng_start) begin g_log.push_back(int'(bus.eng_sel)); g_cyc.push_back(cyc); end
            if (bus.ack_pls != '0) begin a_log.push_back(int'(bus.ack_pls)); a_cyc.push_back(cyc); end
            if (bus.timeout) t_cyc.push_back(cyc);
        end
    end

    // Engine model: answers a start after a chosen latency; may emit stray done pulses.
    initial begin
        bus.eng_done = 1'b0;
        forever begin
            @(posedge s_clk);
            #1;
            bus.eng_done = 1'b0;
            if (!srst_n) cd = 0;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) bus.eng_done = 1'b1;
            end else if (stray && $urandom_range(0, 15) == 0) bus.eng_done = 1'b1;
        end
    end

    initial forever begin
        @(negedge s_clk);
        if (srst_n && bus.eng_start) cd = rnd_lat ? int'($urandom_range(1, TMO + 3)) : eng_lat;
    end

    task automatic step(input logic [N-1:0] r, input logic oc = 1'b0);
        @(posedge s_clk);
        #1;
        bus.req_pls = r;
        bus.ovr_clr = oc;
    endtask

    task automatic idle(input int n);
        repeat (n) step('0);
    endtask

    task automatic do_reset();
        @(posedge s_clk);
        #1;
        srst_n = 1'b0;
        bus.req_pls = '0;
        bus.ovr_clr = 1'b0;
        repeat (2) @(posedge s_clk);
        #1;
        srst_n = 1'b1;
        g_log.delete(); g_cyc.delete(); a_log.delete(); a_cyc.delete(); t_cyc.delete();
    endtask

    initial begin
        int c0;
        bus.req_pls = '0;
        bus.ovr_clr = 1'b0;
        repeat (3) @(posedge s_clk);
        #1;
        srst_n = 1'b1;

        // single request on channel 2, done 3 cycles after start
        do_reset();
        eng_lat = 3;
        step(4'b0100); c0 = cyc;
        idle(10);
        chk("single_grants", g_log.size(), 1);
        if (g_log.size() == 1) begin
            chk("single_sel", g_log[0], 2);
            chk("single_start_cyc", g_cyc[0] - c0, 2);
        end
        chk("single_acks", a_log.size(), 1);
        if (a_log.size() == 1) begin
            chk("single_ack_vec", a_log[0], 4);
            chk("single_ack_cyc", a_cyc[0] - c0, 6);
        end
        chk("single_overrun", int'(bus.overrun), 0);

        // round robin from reset
        do_reset();
        eng_lat = 1;
        step(4'b1111);
        idle(20);
        step(4'b1001);
        idle(12);
        chk("rr_grants", g_log.size(), 6);
        if (g_log.size() == 6) begin
            for (int i = 0; i < 4; i++) chk("rr_order", g_log[i], i);
            chk("rr_second_a", g_log[4], 0);
            chk("rr_second_b", g_log[5], 3);
        end

        // overrun while channel 1 waits
        do_reset();
        eng_lat = 6;
        step(4'b0010);
        idle(3);
        step(4'b0010);
        step('0);
        @(negedge s_clk);
        chk("ovr_set", int'(bus.overrun), 4'b0010);
        idle(8);
        chk("ovr_single_ack", a_log.size(), 1);
        step('0, 1'b1);
        step('0);
        @(negedge s_clk);
        chk("ovr_cleared", int'(bus.overrun), 0);

        // re-request in the ACK cycle of the same channel
        do_reset();
        eng_lat = 2;
        step(4'b0010);
        idle(4);
        step(4'b0010);
        idle(10);
        chk("setclr_grants", g_log.size(), 2);
        if (g_log.size() == 2) chk("setclr_second", g_log[1], 1);
        chk("setclr_overrun", int'(bus.overrun), 0);

        // timeouts, then the done-at-expiry race, then a stray done in IDLE
        do_reset();
        eng_lat = 100;
        step(4'b0001); c0 = cyc;
        step(4'b0100);
        idle(45);
        chk("tmo_count", t_cyc.size(), 2);
        if (t_cyc.size() >= 1) chk("tmo_cyc", t_cyc[0] - c0, 19);
        chk("tmo_no_ack", a_log.size(), 0);
        if (g_log.size() == 2) chk("tmo_next_grant", g_log[1], 2);
        else chk("tmo_grants", g_log.size(), 2);
        eng_lat = 16;
        step(4'b0001); c0 = cyc;
        idle(22);
        chk("race_acks", a_log.size(), 1);
        if (a_log.size() == 1) chk("race_ack_cyc", a_cyc[0] - c0, 19);
        chk("race_no_tmo", t_cyc.size(), 2);
        @(posedge s_clk);
        #2;
        bus.eng_done = 1'b1;
        idle(3);
        chk("stray_busy", int'(bus.busy), 0);
        chk("stray_acks", a_log.size(), 1);

        // reset in the middle of WAIT
        do_reset();
        eng_lat = 100;
        step(4'b0001);
        idle(3);
        @(posedge s_clk);
        #1;
        srst_n = 1'b0;
        @(negedge s_clk);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_start", int'(bus.eng_start), 0);
        repeat (2) @(posedge s_clk);
        #1;
        srst_n = 1'b1;
        idle(30);
        chk("midrst_grants", g_log.size(), 1);
        chk("midrst_acks", a_log.size(), 0);
        chk("midrst_tmo", t_cyc.size(), 0);

        // randomized traffic with random engine latency and stray done pulses
        do_reset();
        rnd_lat = 1;
        stray   = 1;
        for (int i = 0; i < 2500; i++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step(r, ($urandom_range(0, 31) == 0));
        end
        stray = 0;
        idle(60);
        chk("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
